// File: rtl/ppc_fetch_pkg.sv
// Shared widths, state encoding and FIFO entry layout for the PPC fetch queue.
package ppc_fetch_pkg;

    localparam int unsigned INST_W    = 32;
    localparam int unsigned ADDR_W    = 64;
    localparam int unsigned DW_ADDR_W = 61;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    // One buffered instruction with its byte address (big-endian bit order).
    typedef struct packed {
        logic [0:INST_W-1] inst;
        logic [0:ADDR_W-1] pc;
    } fetch_entry_t;

endpackage

// File: rtl/ppc_fetch_fifo.sv
// Circular instruction buffer: up to two pushes and one pop per cycle,
// synchronous flush. DEPTH must be a power of two so pointers wrap naturally.
module ppc_fetch_fifo
    import ppc_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   pushOne,
    input  logic                   pushTwo,
    input  logic                   pop,
    input  fetch_entry_t           wrEntry0,
    input  fetch_entry_t           wrEntry1,
    output fetch_entry_t           headEntry,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] tailPlus1;
    logic [CNT_W-1:0] pushNum;

    assign tailPlus1 = tail + PTR_W'(1);
    assign headEntry = mem[head];

    // Number of entries written this cycle.
    always_comb begin
        pushNum = '0;
        if (pushTwo) begin
            pushNum = CNT_W'(2);
        end else if (pushOne) begin
            pushNum = CNT_W'(1);
        end
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pushOne || pushTwo) begin
                mem[tail] <= wrEntry0;
            end
            if (pushTwo) begin
                mem[tailPlus1] <= wrEntry1;
            end
            tail  <= tail + PTR_W'(pushNum);
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            count <= count + pushNum - CNT_W'(pop);
        end
    end

endmodule

// File: rtl/ppc_fetch_queue.sv
// PPC instruction fetch stage: splits 64-bit big-endian memory words into two
// instructions, buffers them and handles redirect/halt. Defining FETCH_PERF_EN
// adds the perf_words / perf_flushes counters.
module ppc_fetch_queue
    import ppc_fetch_pkg::*;
#(
    parameter int unsigned       DEPTH    = 4,
    parameter logic [0:ADDR_W-1] RESET_PC = 64'h0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [0:DW_ADDR_W-1]   mem_addr,
    input  logic [0:2*INST_W-1]    mem_data,
    input  logic                   redirect_valid,
    input  logic [0:ADDR_W-1]      redirect_pc,
    input  logic                   halt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [0:INST_W-1]      out_inst,
    output logic [0:ADDR_W-1]      out_pc,
    output logic                   misalign_err
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]            perf_words,
    output logic [31:0]            perf_flushes
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t      state;
    fetch_state_t      stateNext;
    logic [0:ADDR_W-1] fetchPc;
    logic [0:ADDR_W-1] fetchPcNext;
    logic              misalignNext;
    logic              flush;
    logic              pushOne;
    logic              pushTwo;
    logic              pop;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  free;
    fetch_entry_t      wrEntry0;
    fetch_entry_t      wrEntry1;
    fetch_entry_t      headEntry;

    assign mem_addr  = fetchPc[0:DW_ADDR_W-1];
    assign free      = CNT_W'(DEPTH) - count;
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign out_inst  = headEntry.inst;
    assign out_pc    = headEntry.pc;

    // Word split: a word-aligned fetch yields both halves, an odd one only the second.
    always_comb begin
        wrEntry0 = '0;
        wrEntry1 = '0;
        if (!fetchPc[61]) begin
            wrEntry0.inst = mem_data[0:INST_W-1];
            wrEntry0.pc   = {fetchPc[0:DW_ADDR_W-1], 3'b000};
            wrEntry1.inst = mem_data[INST_W:2*INST_W-1];
            wrEntry1.pc   = {fetchPc[0:DW_ADDR_W-1], 3'b100};
        end else begin
            wrEntry0.inst = mem_data[INST_W:2*INST_W-1];
            wrEntry0.pc   = {fetchPc[0:DW_ADDR_W-1], 3'b100};
        end
    end

    // Next state: halt > misaligned redirect > redirect > normal fetch.
    always_comb begin
        stateNext    = state;
        fetchPcNext  = fetchPc;
        misalignNext = misalign_err;
        flush        = 1'b0;
        pushOne      = 1'b0;
        pushTwo      = 1'b0;
        case (state)
            RUN: begin
                if (halt) begin
                    stateNext = HALTED;
                    flush     = 1'b1;
                end else if (redirect_valid && (redirect_pc[62:63] != 2'b00)) begin
                    misalignNext = 1'b1;
                    stateNext    = HALTED;
                    flush        = 1'b1;
                end else if (redirect_valid) begin
                    flush       = 1'b1;
                    fetchPcNext = redirect_pc;
                end else begin
                    if (!fetchPc[61] && (free >= CNT_W'(2))) begin
                        pushTwo = 1'b1;
                    end else if (fetchPc[61] && (free >= CNT_W'(1))) begin
                        pushOne = 1'b1;
                    end
                    if (pushOne || pushTwo) begin
                        fetchPcNext = {fetchPc[0:DW_ADDR_W-1] + DW_ADDR_W'(1), 3'b000};
                    end
                end
            end
            HALTED: begin
                flush = halt;
            end
            default: begin
                stateNext = HALTED;
                flush     = 1'b1;
            end
        endcase
    end

    // State, fetch PC and sticky misalignment flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            fetchPc      <= RESET_PC;
            misalign_err <= 1'b0;
        end else begin
            state        <= stateNext;
            fetchPc      <= fetchPcNext;
            misalign_err <= misalignNext;
        end
    end

`ifdef FETCH_PERF_EN
    // Pushing fetch cycles and flushes taken while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_words   <= '0;
            perf_flushes <= '0;
        end else begin
            if (pushOne || pushTwo) begin
                perf_words <= perf_words + 32'd1;
            end
            if ((state == RUN) && flush) begin
                perf_flushes <= perf_flushes + 32'd1;
            end
        end
    end
`endif

    ppc_fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .pushOne  (pushOne),
        .pushTwo  (pushTwo),
        .pop      (pop),
        .wrEntry0 (wrEntry0),
        .wrEntry1 (wrEntry1),
        .headEntry(headEntry),
        .count    (count)
    );

endmodule
